// File: rtl/up_stream_buffer.sv
// Elastic FWFT buffer between the PAICore up-transport stage and the S2MM DMA.
// Counts data words per receive session and flags the end-marker departure.
module up_stream_buffer #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [63:0]       s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [63:0]       m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              i_rx_rcving,
    output logic [CNT_W-1:0]  o_word_count,
    output logic [ADDR_W:0]   o_level,
    output logic              o_rx_end,
    output logic              o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [64:0]      mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [64:0]      rd_word;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;
    logic             rcv_q;
    logic             rcv_rise;
    logic             rd_last;
    logic             cnt_max;
    state_t           state;

    // Occupancy flags come only from registered pointers, so neither
    // handshake side has a combinational path to the other.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0])
                && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty;

    assign wr_en = s_axis_tvalid && !full;
    assign rd_en = !empty && m_axis_tready;

    // Head entry is read straight out of storage; it only changes on a read.
    assign rd_word      = mem[rd_ptr[ADDR_W-1:0]];
    assign m_axis_tdata = rd_word[63:0];
    assign m_axis_tlast = rd_word[64];
    assign rd_last      = rd_word[64];

    assign o_level = wr_ptr - rd_ptr;
    assign o_busy  = (state == RUN) || !empty;

    assign rcv_rise = i_rx_rcving && !rcv_q;
    assign cnt_max  = &o_word_count;

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Write/read pointers with wrap bit; reset drops everything buffered.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Session FSM: counts forwarded data words in RUN, pulses on marker exit.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state        <= IDLE;
            rcv_q        <= 1'b0;
            o_word_count <= '0;
            o_rx_end     <= 1'b0;
        end else begin
            rcv_q    <= i_rx_rcving;
            o_rx_end <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rcv_rise) begin
                        state        <= RUN;
                        o_word_count <= '0;
                    end
                end
                RUN: begin
                    if (rd_en && rd_last) begin
                        state    <= DONE;
                        o_rx_end <= 1'b1;
                    end else begin
                        if (rd_en && !cnt_max) begin
                            o_word_count <= o_word_count + 1'b1;
                        end
                        if (!i_rx_rcving) begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!i_rx_rcving) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_stream_buffer.sv
// Directed bench for up_stream_buffer with a queue reference for ordering.
// Checks are immediate assertions; summary line at the end.
module tb_up_stream_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        i_rx_rcving;
    logic [31:0] o_word_count;
    logic [4:0]  o_level;
    logic        o_rx_end;
    logic        o_busy;

    int errors = 0;
    int checks = 0;
    int rx_ends = 0;
    int popped = 0;
    logic last_wr = 1'b0;
    logic [64:0] q[$];

    localparam logic [63:0] MARK = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    up_stream_buffer #(.ADDR_W(4), .CNT_W(32)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .i_rx_rcving    (i_rx_rcving),
        .o_word_count   (o_word_count),
        .o_level        (o_level),
        .o_rx_end       (o_rx_end),
        .o_busy         (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the reference queue, then advance one clock.
    task automatic cyc();
        logic mv;
        logic sr;
        logic rd;
        logic wr;
        mv = (q.size() != 0);
        sr = (q.size() < 16);
        chk("s_tready", s_axis_tready, sr);
        chk("m_tvalid", m_axis_tvalid, mv);
        chk("level", o_level, q.size());
        if (mv) begin
            chk("m_tdata", m_axis_tdata, q[0][63:0]);
            chk("m_tlast", m_axis_tlast, q[0][64]);
        end
        rd = mv && m_axis_tready;
        wr = s_axis_tvalid && sr;
        @(posedge clk);
        #1;
        if (rd) begin
            void'(q.pop_front());
            popped++;
        end
        if (wr) q.push_back({s_axis_tlast, s_axis_tdata});
        last_wr = wr;
        if (o_rx_end) rx_ends++;
    endtask

    task automatic push_word(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        do begin
            cyc();
            n++;
        end while (!last_wr && n < 200);
        chk("push_accept", last_wr, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        int base;
        int acc;
        int guard;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        i_rx_rcving   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_level", o_level, 5'd0);
        chk("rst_count", o_word_count, 32'd0);
        chk("rst_rx_end", o_rx_end, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_tready", s_axis_tready, 1'b1);

        // Session: 8 words then end marker, sink always ready
        i_rx_rcving   = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        chk("run_busy", o_busy, 1'b1);
        for (int i = 0; i < 8; i++) push_word(64'(i), 1'b0);
        chk("lat1_tvalid", m_axis_tvalid, 1'b1);
        chk("lat1_tdata", m_axis_tdata, 64'd7);
        push_word(MARK, 1'b1);
        repeat (3) cyc();
        chk("s1_count", o_word_count, 32'd8);
        chk("s1_rx_end", rx_ends, 1);
        chk("s1_busy", o_busy, 1'b0);
        i_rx_rcving = 1'b0;
        cyc();

        // Fill to full with the sink stalled
        m_axis_tready = 1'b0;
        base = popped;
        for (int i = 0; i < 16; i++) push_word(64'(100 + i), 1'b0);
        chk("full_tready", s_axis_tready, 1'b0);
        chk("full_level", o_level, 5'd16);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'd116;
        repeat (2) cyc();
        chk("full_refuse", last_wr, 1'b0);
        chk("full_level2", o_level, 5'd16);

        // Full with read and write offered together: only the read happens
        m_axis_tready = 1'b1;
        cyc();
        chk("fr_wr_refused", last_wr, 1'b0);
        chk("fr_level", o_level, 5'd15);
        chk("fr_tready", s_axis_tready, 1'b1);
        for (int i = 16; i < 20; i++) push_word(64'(100 + i), 1'b0);
        repeat (20) cyc();
        chk("fill_popped", popped - base, 20);
        chk("fill_empty", o_level, 5'd0);
        chk("idle_count_held", o_word_count, 32'd8);

        // Random handshakes with pointer wrap
        acc   = 0;
        guard = 0;
        while (acc < 2000 && guard < 20000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if (!s_axis_tvalid) begin
                s_axis_tvalid = 1'($urandom_range(0, 1));
                s_axis_tdata  = {$urandom, $urandom};
            end
            cyc();
            guard++;
            if (last_wr) begin
                acc++;
                s_axis_tvalid = 1'b0;
            end
        end
        chk("rand_words", acc, 2000);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (20) cyc();
        chk("rand_drain", o_level, 5'd0);
        chk("rand_count_held", o_word_count, 32'd8);

        // Session aborted before the marker
        i_rx_rcving = 1'b1;
        cyc();
        chk("s5_clear", o_word_count, 32'd0);
        for (int i = 0; i < 5; i++) push_word(64'(200 + i), 1'b0);
        repeat (3) cyc();
        chk("s5_count", o_word_count, 32'd5);
        base = rx_ends;
        i_rx_rcving = 1'b0;
        cyc();
        push_word(MARK, 1'b1);
        repeat (3) cyc();
        chk("s5_no_rx_end", rx_ends, base);
        chk("s5_count_held", o_word_count, 32'd5);
        chk("s5_busy", o_busy, 1'b0);
        i_rx_rcving = 1'b1;
        cyc();
        chk("s5_reclear", o_word_count, 32'd0);

        // Reset with words buffered
        for (int i = 0; i < 3; i++) push_word(64'(300 + i), 1'b0);
        repeat (3) cyc();
        chk("s6_count", o_word_count, 32'd3);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 9; i++) push_word(64'(400 + i), 1'b0);
        chk("s6_level", o_level, 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_level", o_level, 5'd0);
        chk("arst_count", o_word_count, 32'd0);
        chk("arst_busy", o_busy, 1'b0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        base = rx_ends;
        cyc();
        for (int i = 0; i < 4; i++) push_word(64'(500 + i), 1'b0);
        push_word(MARK, 1'b1);
        repeat (4) cyc();
        chk("post_count", o_word_count, 32'd4);
        chk("post_rx_end", rx_ends, base + 1);
        chk("post_empty", o_level, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
